// File: rtl/hcordic_issue_arbiter_pkg.sv
// Shared types for the HCORDIC issue front-end: FSM states, requester id,
// default NOP packet and the two-way round-robin pick rule.
package hcordic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef logic req_id_t;

   localparam logic [15:0] NOP_PACKET_DEFAULT = 16'h0000;

   // Contention goes to the requester not served last; otherwise the lone
   // valid requester wins (0 when nobody is valid, qualified by the caller).
   function automatic req_id_t rr_pick(input logic [1:0] valid, input req_id_t last);
      if (&valid) begin
         return ~last;
      end
      return valid[1];
   endfunction

endpackage

// File: rtl/hcordic_issue_arbiter_if.sv
// Request, pipeline and response signals of the HCORDIC issue arbiter.
// slave = arbiter side, master = requesters/pipeline/consumer side.
interface hcordic_issue_arbiter_if;

   logic        req0_valid;
   logic [15:0] req0_packet;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_packet;
   logic        req1_ready;

   logic [15:0] InstructionPacket;
   logic [31:0] pipe_x;
   logic [31:0] pipe_y;
   logic [31:0] pipe_z;
   logic        pipe_done;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_x;
   logic [31:0] rsp_y;
   logic [31:0] rsp_z;
   logic        rsp_timeout;

   logic        busy;
   logic        stray_done;

   modport slave (
      input  req0_valid, req0_packet, req1_valid, req1_packet,
      input  pipe_x, pipe_y, pipe_z, pipe_done, rsp_ready,
      output req0_ready, req1_ready, InstructionPacket,
      output rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout,
      output busy, stray_done
   );

   modport master (
      output req0_valid, req0_packet, req1_valid, req1_packet,
      output pipe_x, pipe_y, pipe_z, pipe_done, rsp_ready,
      input  req0_ready, req1_ready, InstructionPacket,
      input  rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout,
      input  busy, stray_done
   );

endinterface

// File: rtl/hcordic_issue_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; last_grant advances only when the grant is
// accepted, so an unaccepted grant does not rotate priority.
module rr_arbiter2
   import hcordic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   input  logic       accept,
   output req_id_t    grant,
   output logic       grant_valid
);

   req_id_t last_grant_q;
   req_id_t last_grant_d;

   assign grant_valid = |req_valid;
   assign grant       = rr_pick(req_valid, last_grant_q);

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept && grant_valid) begin
         last_grant_d = grant;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/hcordic_issue_arbiter.sv
// HCORDIC front-end: round-robin issue of one packet at a time to the pipeline,
// watchdog-bounded wait for done, and a held response on a shared channel.
module hcordic_issue_arbiter
   import hcordic_pkg::*;
#(
   parameter logic [15:0] NOP_PACKET = NOP_PACKET_DEFAULT,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CNT_W      = 11
) (
   input logic                    clock,
   input logic                    reset,
   hcordic_issue_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [15:0]      instr_q, instr_d;
   req_id_t          id_q, id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   req_id_t          rsp_id_q, rsp_id_d;
   logic [31:0]      rsp_x_q, rsp_x_d;
   logic [31:0]      rsp_y_q, rsp_y_d;
   logic [31:0]      rsp_z_q, rsp_z_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             stray_q, stray_d;

   req_id_t          grant;
   logic             grant_valid;
   logic             handshake;

   rr_arbiter2 u_arb (
      .clk        (clock),
      .rst        (reset),
      .req_valid  ({bus.req1_valid, bus.req0_valid}),
      .accept     (handshake),
      .grant      (grant),
      .grant_valid(grant_valid)
   );

   // Ready is suppressed while reset is high so no packet is accepted and then lost.
   assign handshake      = (state_q == IDLE) && grant_valid && !reset;
   assign bus.req0_ready = handshake && (grant == 1'b0) && bus.req0_valid;
   assign bus.req1_ready = handshake && (grant == 1'b1) && bus.req1_valid;
   assign bus.busy       = (state_q != IDLE);

   always_comb begin
      state_d       = state_q;
      instr_d       = NOP_PACKET;
      id_d          = id_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = 1'b0;
      rsp_id_d      = rsp_id_q;
      rsp_x_d       = rsp_x_q;
      rsp_y_d       = rsp_y_q;
      rsp_z_d       = rsp_z_q;
      rsp_timeout_d = rsp_timeout_q;
      stray_d       = stray_q || (bus.pipe_done && (state_q != WAIT));

      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               id_d    = grant;
               instr_d = grant ? bus.req1_packet : bus.req0_packet;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A done arriving on the watchdog's last cycle still counts as a result.
            if (bus.pipe_done) begin
               rsp_x_d       = bus.pipe_x;
               rsp_y_d       = bus.pipe_y;
               rsp_z_d       = bus.pipe_z;
               rsp_timeout_d = 1'b0;
               rsp_id_d      = id_q;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_x_d       = '0;
               rsp_y_d       = '0;
               rsp_z_d       = '0;
               rsp_timeout_d = 1'b1;
               rsp_id_d      = id_q;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         instr_q       <= NOP_PACKET;
         id_q          <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_x_q       <= '0;
         rsp_y_q       <= '0;
         rsp_z_q       <= '0;
         rsp_timeout_q <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         id_q          <= id_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_x_q       <= rsp_x_d;
         rsp_y_q       <= rsp_y_d;
         rsp_z_q       <= rsp_z_d;
         rsp_timeout_q <= rsp_timeout_d;
         stray_q       <= stray_d;
      end
   end

   assign bus.InstructionPacket = instr_q;
   assign bus.rsp_valid         = rsp_valid_q;
   assign bus.rsp_id            = rsp_id_q;
   assign bus.rsp_x             = rsp_x_q;
   assign bus.rsp_y             = rsp_y_q;
   assign bus.rsp_z             = rsp_z_q;
   assign bus.rsp_timeout       = rsp_timeout_q;
   assign bus.stray_done        = stray_q;

endmodule
